// File: rtl/cache_sa_ctrl.sv
// cache_sa_ctrl: two-way set-associative cache controller with per-set LRU and a
// single-word handshake memory port, in write-back or write-through flavour.
module cache_sa_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int WRITE_BACK = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int BO_W  = $clog2(DATA_W / 8);
  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int IX_W  = $clog2(SETS);
  localparam int TAG_W = ADDR_W - BO_W - WO_W - IX_W;

  localparam logic [WO_W-1:0] WO_ZERO = {WO_W{1'b0}};
  localparam logic [WO_W-1:0] WO_ONE  = WO_W'(1);
  localparam logic [WO_W-1:0] WO_LAST = WO_W'(LINE_WORDS - 1);
  localparam logic [BO_W-1:0] BO_ZERO = {BO_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WBACK  = 3'd2,
    FILL   = 3'd3,
    WTHRU  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 victim_q, victim_d;
  logic [WO_W-1:0]      cnt_q, cnt_d;
  logic                 hit_flag_q, hit_flag_d;
  logic [DATA_W-1:0]    resp_data_q, resp_data_d;
  logic [1:0][SETS-1:0] valid_q, valid_d;
  logic [1:0][SETS-1:0] dirty_q, dirty_d;
  logic [SETS-1:0]      lru_q, lru_d;

  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic                 cpu_hit_q, cpu_hit_d;
  logic                 cpu_busy_q, cpu_busy_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;

  // Line storage keeps its contents across reset; only the valid bits are cleared.
  logic [DATA_W-1:0]    data_arr [2][SETS*LINE_WORDS];
  logic [TAG_W-1:0]     tag_arr  [2][SETS];
  logic                 arr_we;
  logic                 arr_way;
  logic [IX_W+WO_W-1:0] arr_ix;
  logic [DATA_W-1:0]    arr_wdata;
  logic                 tag_we;

  logic [TAG_W-1:0]     req_tag;
  logic [IX_W-1:0]      req_idx;
  logic [WO_W-1:0]      req_wo;
  logic                 hit0, hit1, hit, hit_way, victim;
  logic [WO_W-1:0]      cnt_nx;
  logic [DATA_W-1:0]    fill_word;

  function automatic logic [IX_W+WO_W-1:0] word_ix(input logic [IX_W-1:0] idx,
                                                   input logic [WO_W-1:0] wo);
    return {idx, wo};
  endfunction

  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx   = addr_q[BO_W+WO_W +: IX_W];
  assign req_wo    = addr_q[BO_W +: WO_W];
  assign hit0      = valid_q[0][req_idx] && (tag_arr[0][req_idx] == req_tag);
  assign hit1      = valid_q[1][req_idx] && (tag_arr[1][req_idx] == req_tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = hit1 && !hit0;
  assign victim    = !valid_q[0][req_idx] ? 1'b0 :
                     !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign cnt_nx    = cnt_q + WO_ONE;
  assign fill_word = (we_q && (cnt_q == req_wo)) ? wdata_q : mem_rdata;

  // Next-state, datapath and memory-port control.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    hit_flag_d  = hit_flag_q;
    resp_data_d = resp_data_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    lru_d       = lru_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = cpu_hit_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    arr_we      = 1'b0;
    arr_way     = victim_q;
    arr_ix      = word_ix(req_idx, req_wo);
    arr_wdata   = wdata_q;
    tag_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = LOOKUP;
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        hit_flag_d = hit;
        if (hit) begin
          lru_d[req_idx] = ~hit_way;
          if (we_q) begin
            arr_we      = 1'b1;
            arr_way     = hit_way;
            resp_data_d = wdata_q;
            if (WRITE_BACK != 0) begin
              dirty_d[hit_way][req_idx] = 1'b1;
              state_d = RESP;
            end else begin
              state_d     = WTHRU;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = addr_q;
              mem_wdata_d = wdata_q;
            end
          end else begin
            resp_data_d = data_arr[hit_way][word_ix(req_idx, req_wo)];
            state_d     = RESP;
          end
        end else if (we_q && (WRITE_BACK == 0)) begin
          // No-write-allocate: straight to memory, cache state untouched.
          resp_data_d = wdata_q;
          state_d     = WTHRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = wdata_q;
        end else begin
          victim_d                = victim;
          cnt_d                   = WO_ZERO;
          mem_req_d               = 1'b1;
          valid_d[victim][req_idx] = 1'b0;
          if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) begin
            state_d     = WBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_arr[victim][req_idx], req_idx, WO_ZERO, BO_ZERO};
            mem_wdata_d = data_arr[victim][word_ix(req_idx, WO_ZERO)];
          end else begin
            state_d     = FILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_idx, WO_ZERO, BO_ZERO};
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end
      end
      WBACK: begin
        if (mem_ack) begin
          if (cnt_q == WO_LAST) begin
            state_d     = FILL;
            cnt_d       = WO_ZERO;
            mem_we_d    = 1'b0;
            mem_addr_d  = {req_tag, req_idx, WO_ZERO, BO_ZERO};
            mem_wdata_d = {DATA_W{1'b0}};
          end else begin
            cnt_d       = cnt_nx;
            mem_addr_d  = {tag_arr[victim_q][req_idx], req_idx, cnt_nx, BO_ZERO};
            mem_wdata_d = data_arr[victim_q][word_ix(req_idx, cnt_nx)];
          end
        end else begin
          state_d = WBACK;
        end
      end
      FILL: begin
        if (mem_ack) begin
          arr_we    = 1'b1;
          arr_ix    = word_ix(req_idx, cnt_q);
          arr_wdata = fill_word;
          if (cnt_q == req_wo) begin
            resp_data_d = fill_word;
          end else begin
            resp_data_d = resp_data_q;
          end
          if (cnt_q == WO_LAST) begin
            state_d                    = RESP;
            mem_req_d                  = 1'b0;
            tag_we                     = 1'b1;
            valid_d[victim_q][req_idx] = 1'b1;
            dirty_d[victim_q][req_idx] = we_q;
            lru_d[req_idx]             = ~victim_q;
          end else begin
            cnt_d      = cnt_nx;
            mem_addr_d = {req_tag, req_idx, cnt_nx, BO_ZERO};
          end
        end else begin
          state_d = FILL;
        end
      end
      WTHRU: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          state_d = WTHRU;
        end
      end
      RESP: begin
        state_d     = IDLE;
        cpu_ready_d = 1'b1;
        cpu_hit_d   = hit_flag_q;
        cpu_rdata_d = resp_data_q;
        if (hit_flag_q) begin
          hit_cnt_d = (hit_cnt_q == 16'hFFFF) ? hit_cnt_q : hit_cnt_q + 16'd1;
        end else begin
          miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    cpu_busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs; async reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      victim_q    <= 1'b0;
      cnt_q       <= WO_ZERO;
      hit_flag_q  <= 1'b0;
      resp_data_q <= {DATA_W{1'b0}};
      valid_q     <= {(2*SETS){1'b0}};
      dirty_q     <= {(2*SETS){1'b0}};
      lru_q       <= {SETS{1'b0}};
      cpu_rdata_q <= {DATA_W{1'b0}};
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      cpu_busy_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      hit_cnt_q   <= 16'h0000;
      miss_cnt_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
      hit_flag_q  <= hit_flag_d;
      resp_data_q <= resp_data_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      lru_q       <= lru_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_busy_q  <= cpu_busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Data and tag array writes.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      data_arr[arr_way][arr_ix] <= arr_wdata;
    end
    if (tag_we) begin
      tag_arr[victim_q][req_idx] <= req_tag;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign cpu_busy  = cpu_busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: doc/cache_sa_ctrl.md
CACHE_SA_CTRL -- requirements
Module: cache_sa_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, word width; multiple of 8.
REQ-003 SHALL have parameter SETS, default 64, set count; power of 2, at least 2.
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per line; power of 2, at least 2.
REQ-005 SHALL have parameter WRITE_BACK, default 1; 1 = write-back/write-allocate, 0 = write-through/no-write-allocate.
REQ-006 SHALL have port clk  in  1  clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports cpu_req in 1 (request pulse), cpu_we in 1 (1 = write), cpu_addr in ADDR_W (byte address), cpu_wdata in DATA_W (write data).
REQ-009 SHALL have ports cpu_rdata out DATA_W (read data), cpu_ready out 1 (completion pulse), cpu_hit out 1 (hit flag, valid with cpu_ready), cpu_busy out 1 (request in progress).
REQ-010 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_ack in 1.
REQ-011 SHALL have ports hit_cnt out 16 and miss_cnt out 16, both saturating.

Function
REQ-012 SHALL decode each address, LSB first, as: byte offset (log2(DATA_W/8) bits), then word offset (log2 LINE_WORDS), then index (log2 SETS), then tag (remaining bits).
REQ-013 SHALL be 2-way set-associative, with valid, dirty and tag bits per way and one LRU bit per set.
REQ-014 SHALL use FSM states IDLE, LOOKUP, WBACK, FILL, WTHRU and RESP.
REQ-015 SHALL accept cpu_req only in IDLE and capture we, addr and wdata on that edge; cpu_req SHALL be ignored while cpu_busy=1.
REQ-016 SHALL drive cpu_busy=1 in every state except IDLE.
REQ-017 SHALL complete a hit in LOOKUP then RESP: cpu_ready is high for exactly one cycle, 2 cycles after the accepting edge, with cpu_hit=1.
REQ-018 SHALL, on a read hit, drive the addressed word on cpu_rdata during the cpu_ready cycle; cpu_rdata holds that value until the next cpu_ready.
REQ-019 SHALL, on a write hit in WRITE_BACK=1 mode, update the word and set dirty, with no memory traffic.
REQ-020 SHALL, on a write hit in WRITE_BACK=0 mode, update the word and issue one memory write in WTHRU before RESP.
REQ-021 SHALL, on a write miss in WRITE_BACK=0 mode, issue one memory write in WTHRU, allocate no line and leave LRU unchanged.
REQ-022 SHALL, on any other miss, select the victim as: invalid way 0 first, else invalid way 1, else the LRU way.
REQ-023 SHALL, if the victim is valid and dirty, first write back LINE_WORDS words in WBACK at {victim tag, index, word 0..LINE_WORDS-1, byte 0}, in ascending order.
REQ-024 SHALL fill the line in FILL by reading LINE_WORDS words in ascending order from word 0, then set valid, set tag, and clear dirty.
REQ-025 SHALL, on a write miss, merge cpu_wdata into the filled line and set dirty.
REQ-026 SHALL respond to a miss in RESP with cpu_hit=0; read data SHALL be the requested word of the filled line.
REQ-027 SHALL hold each memory transfer (mem_req, mem_we, mem_addr, mem_wdata) stable until the edge where mem_ack=1; one word transfers per ack.
REQ-028 SHALL keep mem_req high across consecutive words of a burst and ignore mem_ack while mem_req=0.
REQ-029 SHALL, on every hit and every fill, point the set's LRU bit at the other way.
REQ-030 SHALL increment hit_cnt or miss_cnt once per cpu_ready, saturating at 0xFFFF.

Reset
REQ-031 SHALL, while rst=1, immediately force all outputs to 0, the FSM to IDLE, and all valid, dirty and LRU bits and both counters to 0.
REQ-032 SHALL, on reset mid-WBACK or mid-FILL, abort the transfer with mem_req=0 immediately and leave no partial line valid.
REQ-033 SHALL NOT reset the data and tag arrays.

Verification (memory model: word at byte address A = 0x1000_0000 | A; defaults; ack 1-3 cycles)
REQ-034 SHALL cover: read 0x0000 -> miss, 4 mem reads 0x0000..0x000C, rdata 0x1000_0000; then read 0x0004 -> hit 2 cycles after accept, rdata 0x1000_0004.
REQ-035 SHALL cover: then read 0x0400 -> miss, fills way 1; then read 0x0000 -> hit; hit_cnt=2, miss_cnt=2.
REQ-036 SHALL cover: then write 0x0008=0xCAFE_F00D -> hit, no mem traffic; then read 0x0800 -> evicts clean 0x0400 line, no writeback; then read 0x0C00 -> 4 mem writes 0x0000..0x000C, 0x0008 carrying 0xCAFE_F00D, then fill, rdata 0x1000_0C00.
REQ-037 SHALL cover, WRITE_BACK=0: write 0x0010=0x1234_5678 -> miss, exactly one mem write; then read 0x0010 -> miss, rdata from memory model.
REQ-038 SHALL cover: rst asserted after 2 FILL acks -> mem_req=0 at once, counters 0; after release, read 0x0000 -> miss.
REQ-039 SHALL cover: cpu_req pulsed while cpu_busy=1 -> ignored, no extra cpu_ready.
